// File: rtl/robo_pkg.sv
// Shared definitions for the pipe cleaner robot.
// Holds the heading codes used by the navigation controller and the
// action-encoding stage, the navigation FSM state type, and the pure
// heading rotation helpers.
package robo_pkg;

    // Heading codes; any other 3-bit value is illegal and recovers to north.
    localparam logic [2:0] ORI_N = 3'b001;
    localparam logic [2:0] ORI_O = 3'b010;
    localparam logic [2:0] ORI_L = 3'b011;
    localparam logic [2:0] ORI_S = 3'b100;

    typedef enum logic [1:0] {
        PARADO  = 2'd0,
        DECIDIR = 2'd1,
        REMOVER = 2'd2,
        FIM     = 2'd3
    } estado_t;

    // Quarter turn to the left: N->O->S->L->N.
    function automatic logic [2:0] gira_esq(input logic [2:0] ori);
        logic [2:0] res;
        case (ori)
            ORI_N:   res = ORI_O;
            ORI_O:   res = ORI_S;
            ORI_S:   res = ORI_L;
            ORI_L:   res = ORI_N;
            default: res = ORI_N;
        endcase
        return res;
    endfunction

    // Quarter turn to the right: N->L->S->O->N.
    function automatic logic [2:0] gira_dir(input logic [2:0] ori);
        logic [2:0] res;
        case (ori)
            ORI_N:   res = ORI_L;
            ORI_L:   res = ORI_S;
            ORI_S:   res = ORI_O;
            ORI_O:   res = ORI_N;
            default: res = ORI_N;
        endcase
        return res;
    endfunction

endpackage

// File: rtl/controle_navegacao.sv
// Left-wall-following navigation controller.
// Each decision cycle samples the sensors and either removes debris,
// turns left, advances or turns right. All outputs are registered.
//
// Ports:
//   clockc3    - system clock, rising edge
//   reset      - asynchronous active-low reset
//   ligar      - run enable (level)
//   head       - wall directly ahead
//   left       - wall on the left
//   lixo       - debris under the robot
//   avancar    - one-cycle pulse per forward step
//   remover    - high while debris is being removed
//   orientacao - current heading (robo_pkg ORI_* codes)
//   passos     - advances since the run started, saturating at MAX_PASSOS
//   fim        - run ended because passos reached MAX_PASSOS
//   preso      - robot trapped (four right turns without an advance)
module controle_navegacao
    import robo_pkg::*;
#(
    parameter int REMOVE_CYCLES = 3,
    parameter int MAX_PASSOS    = 255,
    parameter int PW            = 8
) (
    input  logic          clockc3,
    input  logic          reset,
    input  logic          ligar,
    input  logic          head,
    input  logic          left,
    input  logic          lixo,
    output logic          avancar,
    output logic          remover,
    output logic [2:0]    orientacao,
    output logic [PW-1:0] passos,
    output logic          fim,
    output logic          preso
);

    localparam int RW = (REMOVE_CYCLES > 1) ? $clog2(REMOVE_CYCLES) : 1;
    localparam logic [RW-1:0] REM_LAST  = RW'(REMOVE_CYCLES - 1);
    localparam logic [PW-1:0] PASSOS_MAX = PW'(MAX_PASSOS);

    estado_t       state_reg,     state_next;
    logic          avancar_reg,   avancar_next;
    logic          remover_reg,   remover_next;
    logic [2:0]    ori_reg,       ori_next;
    logic [PW-1:0] passos_reg,    passos_next;
    logic          fim_reg,       fim_next;
    logic          preso_reg,     preso_next;
    logic          virou_reg,     virou_next;
    logic [2:0]    giros_reg,     giros_next;
    logic [RW-1:0] rem_cnt_reg,   rem_cnt_next;
    logic          decidir;

    always_ff @(posedge clockc3 or negedge reset) begin
        if (!reset) begin
            state_reg   <= PARADO;
            avancar_reg <= 1'b0;
            remover_reg <= 1'b0;
            ori_reg     <= ORI_N;
            passos_reg  <= '0;
            fim_reg     <= 1'b0;
            preso_reg   <= 1'b0;
            virou_reg   <= 1'b0;
            giros_reg   <= 3'd0;
            rem_cnt_reg <= '0;
        end else begin
            state_reg   <= state_next;
            avancar_reg <= avancar_next;
            remover_reg <= remover_next;
            ori_reg     <= ori_next;
            passos_reg  <= passos_next;
            fim_reg     <= fim_next;
            preso_reg   <= preso_next;
            virou_reg   <= virou_next;
            giros_reg   <= giros_next;
            rem_cnt_reg <= rem_cnt_next;
        end
    end

    always_comb begin
        state_next   = state_reg;
        avancar_next = 1'b0;
        remover_next = 1'b0;
        // An illegal heading code snaps back to north on the next edge.
        ori_next     = (ori_reg == ORI_N || ori_reg == ORI_O ||
                        ori_reg == ORI_L || ori_reg == ORI_S) ? ori_reg : ORI_N;
        passos_next  = passos_reg;
        fim_next     = fim_reg;
        preso_next   = preso_reg;
        virou_next   = virou_reg;
        giros_next   = giros_reg;
        rem_cnt_next = rem_cnt_reg;
        decidir      = 1'b0;

        case (state_reg)
            PARADO: begin
                passos_next = '0;
                virou_next  = 1'b0;
                giros_next  = 3'd0;
                fim_next    = 1'b0;
                preso_next  = 1'b0;
                if (ligar) state_next = DECIDIR;
            end
            DECIDIR: decidir = 1'b1;
            REMOVER: begin
                // The edge ending the last removal cycle is itself a
                // decision edge, so no idle cycle follows a removal.
                if (rem_cnt_reg == REM_LAST) begin
                    decidir = 1'b1;
                end else begin
                    rem_cnt_next = rem_cnt_reg + 1'b1;
                    remover_next = 1'b1;
                end
            end
            FIM: begin
                if (!ligar) begin
                    state_next  = PARADO;
                    passos_next = '0;
                    fim_next    = 1'b0;
                    preso_next  = 1'b0;
                    virou_next  = 1'b0;
                    giros_next  = 3'd0;
                end
            end
            default: state_next = PARADO;
        endcase

        if (decidir) begin
            if (!ligar) begin
                state_next  = PARADO;
                passos_next = '0;
                virou_next  = 1'b0;
                giros_next  = 3'd0;
                fim_next    = 1'b0;
                preso_next  = 1'b0;
            end else if (lixo) begin
                state_next   = REMOVER;
                rem_cnt_next = '0;
                remover_next = 1'b1;
            end else if (!left && !virou_reg) begin
                // virou_esq forbids two consecutive left turns in open space.
                state_next = DECIDIR;
                ori_next   = gira_esq(ori_next);
                virou_next = 1'b1;
            end else if (!head) begin
                avancar_next = 1'b1;
                passos_next  = (passos_reg == PASSOS_MAX) ? passos_reg
                                                          : passos_reg + 1'b1;
                virou_next   = 1'b0;
                giros_next   = 3'd0;
                if (passos_next == PASSOS_MAX) begin
                    state_next = FIM;
                    fim_next   = 1'b1;
                end else begin
                    state_next = DECIDIR;
                end
            end else begin
                ori_next   = gira_dir(ori_next);
                virou_next = 1'b0;
                giros_next = giros_reg + 3'd1;
                if (giros_next == 3'd4) begin
                    state_next = FIM;
                    preso_next = 1'b1;
                end else begin
                    state_next = DECIDIR;
                end
            end
        end
    end

    assign avancar    = avancar_reg;
    assign remover    = remover_reg;
    assign orientacao = ori_reg;
    assign passos     = passos_reg;
    assign fim        = fim_reg;
    assign preso      = preso_reg;

endmodule

// File: tb/tb_controle_navegacao.sv
// Directed bench for controle_navegacao (MAX_PASSOS = 4 so the end-of-run
// path is reachable quickly). One line is printed per transaction checked.
module tb_controle_navegacao;
    import robo_pkg::*;

    logic       clockc3;
    logic       reset;
    logic       ligar, head, left, lixo;
    logic       avancar, remover, fim, preso;
    logic [2:0] orientacao;
    logic [7:0] passos;

    int checks = 0;
    int errors = 0;

    controle_navegacao #(
        .REMOVE_CYCLES(3),
        .MAX_PASSOS(4),
        .PW(8)
    ) dut (
        .clockc3(clockc3),
        .reset(reset),
        .ligar(ligar),
        .head(head),
        .left(left),
        .lixo(lixo),
        .avancar(avancar),
        .remover(remover),
        .orientacao(orientacao),
        .passos(passos),
        .fim(fim),
        .preso(preso)
    );

    initial clockc3 = 1'b0;
    always #5 clockc3 = ~clockc3;

    task automatic tick;
        @(posedge clockc3);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            $display("check %-22s observed %0h expected %0h ok", tag, obs, exp);
        else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset;
        reset = 1'b0;
        tick;
        tick;
        reset = 1'b1;
    endtask

    initial begin
        ligar = 0; head = 0; left = 1; lixo = 0;
        do_reset;

        // Reset values
        check("rst_avancar", 32'(avancar), 0);
        check("rst_remover", 32'(remover), 0);
        check("rst_ori", 32'(orientacao), 32'(ORI_N));
        check("rst_passos", 32'(passos), 0);
        check("rst_fim", 32'(fim), 0);
        check("rst_preso", 32'(preso), 0);
        check("rst_state", 32'(dut.state_reg), 32'(PARADO));

        // Open corridor with wall on the left: advance every cycle from cycle 2
        ligar = 1; head = 0; left = 1; lixo = 0;
        tick;
        check("c1_avancar", 32'(avancar), 0);
        tick;
        check("c2_avancar", 32'(avancar), 1);
        check("c2_passos", 32'(passos), 1);
        check("c2_ori", 32'(orientacao), 32'(ORI_N));
        tick;
        check("c3_avancar", 32'(avancar), 1);
        check("c3_passos", 32'(passos), 2);
        tick;
        check("c4_passos", 32'(passos), 3);
        ligar = 0;
        tick;
        check("stop_avancar", 32'(avancar), 0);
        check("stop_state", 32'(dut.state_reg), 32'(PARADO));
        tick;
        check("stop_passos", 32'(passos), 0);

        // Left opening: left turn, forced advance, left turn again
        ligar = 1; head = 0; left = 0;
        tick;
        tick;
        check("lt1_ori", 32'(orientacao), 32'(ORI_O));
        check("lt1_avancar", 32'(avancar), 0);
        tick;
        check("lt_adv_avancar", 32'(avancar), 1);
        check("lt_adv_ori", 32'(orientacao), 32'(ORI_O));
        check("lt_adv_passos", 32'(passos), 1);
        tick;
        check("lt2_ori", 32'(orientacao), 32'(ORI_S));
        check("lt2_avancar", 32'(avancar), 0);
        ligar = 0;
        tick;
        tick;
        check("parado_keeps_ori", 32'(orientacao), 32'(ORI_S));

        // Debris removal, sensors toggled inside the window
        do_reset;
        ligar = 1; head = 0; left = 1; lixo = 0;
        tick;
        tick;
        check("pre_rem_passos", 32'(passos), 1);
        lixo = 1;
        tick;
        check("rem1_remover", 32'(remover), 1);
        check("rem1_avancar", 32'(avancar), 0);
        check("rem1_passos", 32'(passos), 1);
        lixo = 0; head = 1; left = 0;
        tick;
        check("rem2_remover", 32'(remover), 1);
        check("rem2_ori", 32'(orientacao), 32'(ORI_N));
        head = 0; left = 1;
        tick;
        check("rem3_remover", 32'(remover), 1);
        check("rem3_passos", 32'(passos), 1);
        tick;
        check("post_rem_remover", 32'(remover), 0);
        check("post_rem_avancar", 32'(avancar), 1);
        check("post_rem_passos", 32'(passos), 2);

        // Reset asserted during the second removal cycle
        lixo = 1;
        tick;
        check("rr1_remover", 32'(remover), 1);
        lixo = 0;
        tick;
        check("rr2_remover", 32'(remover), 1);
        #2 reset = 1'b0;
        #1;
        check("async_remover", 32'(remover), 0);
        check("async_ori", 32'(orientacao), 32'(ORI_N));
        tick;
        reset = 1'b1;
        check("after_rst_state", 32'(dut.state_reg), 32'(PARADO));
        check("after_rst_ori", 32'(orientacao), 32'(ORI_N));
        ligar = 0;

        // Boxed in: four right turns then trapped
        do_reset;
        ligar = 1; head = 1; left = 1; lixo = 0;
        tick;
        tick;
        check("rt1_ori", 32'(orientacao), 32'(ORI_L));
        tick;
        check("rt2_ori", 32'(orientacao), 32'(ORI_S));
        tick;
        check("rt3_ori", 32'(orientacao), 32'(ORI_O));
        check("rt3_preso", 32'(preso), 0);
        tick;
        check("rt4_ori", 32'(orientacao), 32'(ORI_N));
        check("rt4_preso", 32'(preso), 1);
        check("rt4_state", 32'(dut.state_reg), 32'(FIM));
        tick;
        check("fim_hold_preso", 32'(preso), 1);
        check("fim_hold_ori", 32'(orientacao), 32'(ORI_N));
        ligar = 0;
        tick;
        check("trap_clr_preso", 32'(preso), 0);
        check("trap_clr_passos", 32'(passos), 0);
        check("trap_clr_state", 32'(dut.state_reg), 32'(PARADO));

        // Run to MAX_PASSOS = 4
        do_reset;
        ligar = 1; head = 0; left = 1; lixo = 0;
        tick;
        tick;
        check("m1_passos", 32'(passos), 1);
        check("m1_fim", 32'(fim), 0);
        tick;
        tick;
        check("m3_passos", 32'(passos), 3);
        check("m3_fim", 32'(fim), 0);
        tick;
        check("m4_avancar", 32'(avancar), 1);
        check("m4_passos", 32'(passos), 4);
        check("m4_fim", 32'(fim), 1);
        tick;
        check("m5_avancar", 32'(avancar), 0);
        check("m5_passos", 32'(passos), 4);
        check("m5_fim", 32'(fim), 1);
        tick;
        check("m6_avancar", 32'(avancar), 0);
        ligar = 0;
        tick;
        check("end_clr_fim", 32'(fim), 0);
        check("end_clr_passos", 32'(passos), 0);

        // ligar=0 outranks debris
        do_reset;
        ligar = 1; lixo = 1;
        tick;
        ligar = 0;
        tick;
        check("prio_remover", 32'(remover), 0);
        check("prio_state", 32'(dut.state_reg), 32'(PARADO));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/controle_navegacao.md
# controle_navegacao

Left-wall-following navigation controller for the pipe cleaner robot. Samples the front, left and debris sensors every cycle and decides whether to advance, turn or remove debris. Maintains the robot's heading and step count. Drives the `avancar`, `remover` and `orientacao` inputs of the action-encoding stage, so its outputs are registered and change only on clock edges.

## Interface
- `REMOVE_CYCLES`, default 3: number of consecutive cycles `remover` is held per debris removal (≥1).
- `MAX_PASSOS`, default 255: advance count at which the run terminates.
- `PW`, default 8: width of the step counter; must satisfy MAX_PASSOS < 2^PW.
- `clockc3` input 1: system clock; all state updates on rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `ligar` input 1: run enable; level-sensitive.
- `head` input 1: 1 = wall directly ahead.
- `left` input 1: 1 = wall on the left.
- `lixo` input 1: 1 = debris under the robot.
- `avancar` output 1: one-cycle pulse per forward step.
- `remover` output 1: high during debris removal.
- `orientacao` output 3: current heading, encoded N=3'b001, O=3'b010, L=3'b011, S=3'b100.
- `passos` output PW: number of advances since the run started.
- `fim` output 1: run finished because `passos` reached MAX_PASSOS.
- `preso` output 1: robot trapped, with four right turns and no advance.

## Operation
- FSM states: PARADO, DECIDIR, REMOVER, FIM.
- PARADO:
  - all pulses low; `passos`, `virou_esq`, `giros` cleared.
  - `ligar`=1 → DECIDIR.
- DECIDIR performs one action per cycle, chosen by the first matching rule:
  1. `ligar`=0 → PARADO; no action.
  2. `lixo`=1 → REMOVER; removal counter loaded to 0.
  3. `left`=0 and `virou_esq`=0 → turn left.
     - heading N→O, O→S, S→L, L→N.
     - set `virou_esq`.
  4. `head`=0 → advance.
     - `avancar` pulses.
     - `passos`+1; clear `virou_esq` and `giros`.
  5. otherwise → turn right.
     - heading N→L, L→S, S→O, O→N.
     - clear `virou_esq`; `giros`+1.
- `virou_esq` exists to prevent endless left spinning in open space: after a left turn, the next decision cannot be another left turn.
- `giros` is a 3-bit counter. When a right turn brings it to 4, `preso` is set and the FSM enters FIM.
- REMOVER:
  - `remover`=1 for exactly REMOVE_CYCLES cycles; sensors are ignored and heading is held.
  - then return to DECIDIR.
  - `ligar` dropping mid-removal does not abort; return to PARADO happens at the next DECIDIR.
- When an advance makes `passos` equal MAX_PASSOS, the FSM goes to FIM and `fim` is set.
- FIM:
  - all pulses low; `passos`, `orientacao`, `fim`, `preso` held.
  - `ligar`=0 → PARADO, which clears `fim`, `preso` and `passos`.
- Heading is never reset by PARADO, only by `reset`.
- Illegal `orientacao` or state codes recover to N and PARADO respectively.

## Timing
- Reset values: state PARADO, `avancar`=0, `remover`=0, `orientacao`=3'b001, `passos`=0, `fim`=0, `preso`=0, `virou_esq`=0, `giros`=0.
- Reset is asserted asynchronously and released synchronously to `clockc3` by the system.
- Sensor inputs are sampled at the rising edge that ends a DECIDIR cycle. The resulting output (`avancar` pulse, new `orientacao`, `remover` rise) is visible in the following cycle, giving 1 cycle of latency.
- PARADO→DECIDIR takes 1 cycle, so the first action appears 2 cycles after `ligar` rises.
- Removal: `remover` high on cycles k+1 … k+REMOVE_CYCLES after the sampling edge k. The next decision samples at the edge ending the last `remover` cycle.
- Simultaneous events:
  - `lixo` outranks all wall rules.
  - `ligar`=0 outranks `lixo`.
  - the advance that reaches MAX_PASSOS still produces its `avancar` pulse, and `fim` rises in the same cycle as that pulse.
- `passos` saturates at MAX_PASSOS and never wraps.
- Reset mid-removal drops `remover` immediately (asynchronous).

## Structure
- Shared package `robo_pkg` holds:
  - heading constants `ORI_N`, `ORI_O`, `ORI_L`, `ORI_S`, shared with the action-encoding stage.
  - the FSM state enum.
  - pure functions `gira_esq` and `gira_dir`, heading→heading.
- No sub-module: the removal counter, `giros` and `passos` are small counters kept inline. The whole block fits in one module of about 200 lines.

## Test plan
- Reset, then `ligar`=1, `head`=0, `left`=1, `lixo`=0 → `avancar` pulses every cycle from cycle 2; `orientacao`=001; `passos` counts 1, 2, 3, …
- Heading N, `left`=0, `head`=0 → cycle n: left turn to O (`avancar`=0); cycle n+1: advance (`virou_esq` blocks a second left turn); then left turn to S.
- `lixo`=1 during DECIDIR, REMOVE_CYCLES=3 → `remover` high exactly 3 cycles with `orientacao` and `passos` unchanged; toggling `head`/`left` during that window has no effect.
- `head`=1, `left`=1 held → right turns N→L→S→O; on the 4th turn `preso`=1 and state FIM. Then `ligar`=0 → `preso`=0, `passos`=0.
- MAX_PASSOS=4, open corridor → 4 `avancar` pulses, `fim`=1 coincident with the 4th, no 5th pulse; `passos` holds at 4.
- Assert `reset` low during the 2nd removal cycle → `remover`=0 immediately; after release `orientacao`=001, state PARADO.
